// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the synchronous FIFO.
// Pointer wrap uses an explicit compare, so DEPTH does not need to be a power of two.
package sync_fifo_pkg;

   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_RD   = 2'b01,
      OP_WR   = 2'b10,
      OP_BOTH = 2'b11
   } fifo_op_e;

   function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port storage array: synchronous write port, registered read port.
// The array itself is never reset; only the read register is.
module sync_fifo_mem #(
   parameter int unsigned DEPTH = 10,
   parameter int unsigned WIDTH = 4,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_data_d;
   logic [WIDTH-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) begin
         rd_data_d = mem_q[rd_addr];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with arbitrary depth; pointers, occupancy count and flags live here.
// Illegal requests (write when full, read when empty) are silently dropped.
module sync_fifo
   import sync_fifo_pkg::*;
#(
   parameter int unsigned DEPTH = 10,
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             asrst,
   input  logic             wren,
   input  logic [WIDTH-1:0] wrdata,
   output logic             full,
   input  logic             rden,
   output logic [WIDTH-1:0] rddata,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [AW-1:0] wr_ptr_d, wr_ptr_q;
   logic [AW-1:0] rd_ptr_d, rd_ptr_q;
   logic [CW-1:0] count_d, count_q;
   logic          wr_ok, rd_ok;
   fifo_op_e      op;

   // Flags come straight from the registered count, so no input reaches an output combinationally.
   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign wr_ok = wren && !full;
   assign rd_ok = rden && !empty;
   assign op    = fifo_op_e'({wr_ok, rd_ok});

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_ok) begin
         wr_ptr_d = AW'(wrap_inc(32'(wr_ptr_q), DEPTH));
      end
      if (rd_ok) begin
         rd_ptr_d = AW'(wrap_inc(32'(rd_ptr_q), DEPTH));
      end
      case (op)
         OP_WR:   count_d = count_q + 1'b1;
         OP_RD:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge asrst) begin
      if (asrst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   sync_fifo_mem #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH),
      .AW    (AW)
   ) u_mem (
      .clk     (clk),
      .rst     (asrst),
      .wr_en   (wr_ok),
      .wr_addr (wr_ptr_q),
      .wr_data (wrdata),
      .rd_en   (rd_ok),
      .rd_addr (rd_ptr_q),
      .rd_data (rddata)
   );

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo (DEPTH=10, WIDTH=4) with hand-computed expectations
// and a small queue scoreboard for the wrap-around rounds.
module tb_sync_fifo;

   localparam int DEPTH = 10;
   localparam int WIDTH = 4;

   logic             clk = 1'b0;
   logic             asrst;
   logic             wren;
   logic [WIDTH-1:0] wrdata;
   logic             full;
   logic             rden;
   logic [WIDTH-1:0] rddata;
   logic             empty;

   int checks = 0;
   int errors = 0;

   sync_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk    (clk),
      .asrst  (asrst),
      .wren   (wren),
      .wrdata (wrdata),
      .full   (full),
      .rden   (rden),
      .rddata (rddata),
      .empty  (empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   logic [WIDTH-1:0] sb_q[$];
   logic [WIDTH-1:0] exp_d;

   initial begin
      asrst  = 1'b1;
      wren   = 1'b0;
      rden   = 1'b0;
      wrdata = '0;
      cyc();
      cyc();
      asrst = 1'b0;
      #1;
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_rddata", 32'(rddata), 0);

      // Fill 0..9, then two dropped writes of 9.
      for (int i = 0; i < DEPTH; i++) begin
         wren   = 1'b1;
         wrdata = WIDTH'(i);
         cyc();
         chk("fill_full", 32'(full), (i == DEPTH - 1) ? 1 : 0);
         chk("fill_empty", 32'(empty), 0);
      end
      wrdata = 4'd9;
      for (int i = 0; i < 2; i++) begin
         cyc();
         chk("ovf_full", 32'(full), 1);
         chk("ovf_count", 32'(dut.count_q), 10);
      end

      // Drain for 12 cycles.
      wren = 1'b0;
      rden = 1'b1;
      for (int k = 0; k < 12; k++) begin
         cyc();
         chk("drain_rddata", 32'(rddata), (k < 9) ? k : 9);
         chk("drain_empty", 32'(empty), (k >= 9) ? 1 : 0);
         chk("drain_full", 32'(full), 0);
      end

      // Refill and half drain.
      rden = 1'b0;
      wren = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         wrdata = WIDTH'(i);
         cyc();
      end
      chk("refill_full", 32'(full), 1);
      wren = 1'b0;
      rden = 1'b1;
      for (int k = 0; k < 5; k++) begin
         cyc();
         chk("half_rddata", 32'(rddata), k);
         chk("half_full", 32'(full), 0);
      end
      chk("half_count", 32'(dut.count_q), 5);

      // Concurrent read and write with 5..9 held.
      wren = 1'b1;
      rden = 1'b1;
      for (int i = 0; i < 10; i++) begin
         wrdata = WIDTH'(i);
         cyc();
         chk("conc_rddata", 32'(rddata), (i < 5) ? i + 5 : i - 5);
         chk("conc_count", 32'(dut.count_q), 5);
         chk("conc_full", 32'(full), 0);
         chk("conc_empty", 32'(empty), 0);
      end
      wren = 1'b0;
      for (int k = 0; k < 15; k++) begin
         cyc();
         chk("tail_rddata", 32'(rddata), (k < 5) ? k + 5 : 9);
         chk("tail_empty", 32'(empty), (k >= 4) ? 1 : 0);
      end

      // Simultaneous request on empty: only the write lands.
      wren   = 1'b1;
      rden   = 1'b1;
      wrdata = 4'd3;
      cyc();
      chk("empty_both_rddata", 32'(rddata), 9);
      chk("empty_both_count", 32'(dut.count_q), 1);
      wren = 1'b0;
      cyc();
      chk("empty_both_read", 32'(rddata), 3);
      chk("empty_both_empty", 32'(empty), 1);

      // Asynchronous reset with five entries stored.
      rden = 1'b0;
      wren = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wrdata = WIDTH'(10 + i);
         cyc();
      end
      wren = 1'b0;
      chk("pre_rst_count", 32'(dut.count_q), 5);
      #2;
      asrst = 1'b1;
      #1;
      chk("arst_empty", 32'(empty), 1);
      chk("arst_full", 32'(full), 0);
      chk("arst_rddata", 32'(rddata), 0);
      cyc();
      asrst = 1'b0;
      chk("arst_wr_ptr", 32'(dut.wr_ptr_q), 0);
      chk("arst_rd_ptr", 32'(dut.rd_ptr_q), 0);
      wren   = 1'b1;
      wrdata = 4'd7;
      cyc();
      wren = 1'b0;
      rden = 1'b1;
      cyc();
      rden = 1'b0;
      chk("post_rst_rddata", 32'(rddata), 7);
      chk("post_rst_empty", 32'(empty), 1);
      chk("post_rst_ptrs", 32'({dut.wr_ptr_q, dut.rd_ptr_q}), 32'h11);

      // Three fill/drain rounds crossing the pointer wrap.
      for (int r = 0; r < 3; r++) begin
         wren = 1'b1;
         for (int i = 0; i < DEPTH; i++) begin
            wrdata = WIDTH'($urandom_range(0, 15));
            sb_q.push_back(wrdata);
            cyc();
         end
         wren = 1'b0;
         chk("wrap_full", 32'(full), 1);
         rden = 1'b1;
         for (int i = 0; i < DEPTH; i++) begin
            cyc();
            exp_d = sb_q.pop_front();
            chk("wrap_rddata", 32'(rddata), 32'(exp_d));
         end
         rden = 1'b0;
         chk("wrap_empty", 32'(empty), 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
